// File: rtl/unsigned_16by8_div.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor,
// one quotient bit per cycle, valid/ready handshakes on both sides.
module unsigned_16by8_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_shift_q, dvd_shift_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [8:0]  part_rem_q, part_rem_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic [8:0]  p;
    logic        ge;
    logic [8:0]  step_rem;
    logic [15:0] step_quo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_shift_q <= '0;
            divisor_q   <= '0;
            part_rem_q  <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_shift_q <= dvd_shift_d;
            divisor_q   <= divisor_d;
            part_rem_q  <= part_rem_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Quotient bits shift into the dividend register as dividend bits leave it.
    always_comb begin
        state_d     = state_q;
        dvd_shift_d = dvd_shift_q;
        divisor_d   = divisor_q;
        part_rem_d  = part_rem_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        p        = {part_rem_q[7:0], dvd_shift_q[15]};
        ge       = (p >= {1'b0, divisor_q});
        step_rem = ge ? (p - {1'b0, divisor_q}) : p;
        step_quo = {dvd_shift_q[14:0], ge};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_shift_d = dividend;
                    divisor_d   = divisor;
                    part_rem_d  = '0;
                    count_d     = 4'd15;
                    state_d     = CALC;
                end
            end
            CALC: begin
                dvd_shift_d = step_quo;
                part_rem_d  = step_rem;
                if (count_q == 4'd0) begin
                    // With a zero divisor the low remainder byte naturally equals dividend[7:0].
                    quotient_d  = (divisor_q == 8'd0) ? 16'hFFFF : step_quo;
                    remainder_d = step_rem[7:0];
                    dbz_d       = (divisor_q == 8'd0);
                    state_d     = DONE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_16by8_div.sv
// Self-checking bench for unsigned_16by8_div: directed boundary cases, backpressure,
// mid-operation reset and a randomized regression against plain / and % arithmetic.
module tb_unsigned_16by8_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int tests;
    int errors;

    unsigned_16by8_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison in the bench funnels through here so counts stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scribble on the input side while the divider is busy; none of it may matter.
    task automatic scribbleInputs();
        in_valid = 1'($urandom);
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    // One complete transaction: accept, wait out the latency, hold for 'stall'
    // cycles of backpressure, then hand the result off. Entered and left at a negedge.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, input int stall);
        logic [15:0] exp_q;
        logic [15:0] exp_r16;
        logic [7:0]  exp_r;
        logic        exp_z;
        int          waited;
        int          lat;

        if (b == 8'd0) begin
            exp_q = 16'hFFFF;
            exp_r = a[7:0];
            exp_z = 1'b1;
        end else begin
            exp_q   = a / {8'd0, b};
            exp_r16 = a % {8'd0, b};
            exp_r   = exp_r16[7:0];
            exp_z   = 1'b0;
        end

        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
        if (!in_ready) return;

        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!out_valid) scribbleInputs();
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;

        checkOutput("latency", lat, 32'd16);
        checkOutput("quotient", {16'd0, quotient}, {16'd0, exp_q});
        checkOutput("remainder", {24'd0, remainder}, {24'd0, exp_r});
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_z});
        checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < stall; i++) begin
            scribbleInputs();
            @(negedge clk);
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_quotient", {16'd0, quotient}, {16'd0, exp_q});
            checkOutput("stall_remainder", {24'd0, remainder}, {24'd0, exp_r});
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("held_quotient", {16'd0, quotient}, {16'd0, exp_q});
        checkOutput("held_remainder", {24'd0, remainder}, {24'd0, exp_r});
    endtask

    // Directed cases first, then the mid-operation reset, then random regression.
    initial begin
        int seen;
        logic [15:0] ra;
        logic [7:0]  rb;

        tests     = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("reset_remainder", {24'd0, remainder}, 32'd0);
        checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);

        applyStimulus(16'd1000, 8'd7, 0);
        applyStimulus(16'd65535, 8'd1, 0);
        applyStimulus(16'd65535, 8'd255, 0);
        applyStimulus(16'd100, 8'd200, 0);
        applyStimulus(16'd0, 8'd13, 0);
        applyStimulus(16'h1234, 8'd0, 0);
        applyStimulus(16'd50, 8'd5, 0);
        applyStimulus(16'd777, 8'd9, 10);

        // Abort 200/3 at the eighth CALC step.
        in_valid = 1'b1;
        dividend = 16'd200;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("abort_remainder", {24'd0, remainder}, 32'd0);
        checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", seen, 32'd0);
        applyStimulus(16'd9, 8'd4, 0);

        for (int n = 0; n < 2000; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
